branch_predict_unit: RTL and testbench

- Parametrised successor to the single-cycle branch resolver.
- Adds a BHT of 2-bit saturating counters, read at ID to predict direction and target.
- Resolves all six RV32I conditional branches at EX from raw operands, including BLTU and BGEU.
- Emits a flush and a corrected PC on mispredict, updates the BHT, and keeps saturating branch and mispredict statistics.

---
 rtl/branch_predict_unit_if.sv | 41 ++++
 rtl/branch_predict_unit.sv | 95 +++++++++
 tb/tb_branch_predict_unit.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_unit_if.sv
// Signal bundle between the pipeline and branch_predict_unit: ID lookup,
// EX resolution and the statistics outputs.
interface branch_predict_unit_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic [XLEN-1:0]  id_pc_i;
   logic [XLEN-1:0]  id_imm_i;
   logic             id_branch_i;
   logic             pred_taken_o;
   logic [XLEN-1:0]  pred_target_o;
   logic             ex_branch_i;
   logic             ex_stall_i;
   logic [XLEN-1:0]  ex_pc_i;
   logic [XLEN-1:0]  ex_imm_i;
   logic [XLEN-1:0]  ex_rs1_i;
   logic [XLEN-1:0]  ex_rs2_i;
   logic [2:0]       ex_func3_i;
   logic             ex_pred_taken_i;
   logic             taken_o;
   logic             flush_o;
   logic [XLEN-1:0]  redirect_pc_o;
   logic [CNT_W-1:0] br_count_o;
   logic [CNT_W-1:0] mispred_count_o;

   modport master (
      output id_pc_i, id_imm_i, id_branch_i,
      output ex_branch_i, ex_stall_i, ex_pc_i, ex_imm_i, ex_rs1_i, ex_rs2_i,
      output ex_func3_i, ex_pred_taken_i,
      input  pred_taken_o, pred_target_o, taken_o, flush_o, redirect_pc_o,
      input  br_count_o, mispred_count_o
   );

   modport slave (
      input  id_pc_i, id_imm_i, id_branch_i,
      input  ex_branch_i, ex_stall_i, ex_pc_i, ex_imm_i, ex_rs1_i, ex_rs2_i,
      input  ex_func3_i, ex_pred_taken_i,
      output pred_taken_o, pred_target_o, taken_o, flush_o, redirect_pc_o,
      output br_count_o, mispred_count_o
   );
endinterface

// File: rtl/branch_predict_unit.sv
// Untagged BHT of 2-bit saturating counters predicting at ID, with EX-stage
// resolution of the RV32I conditional branches, mispredict redirect and stats.
module branch_predict_unit #(
   parameter int XLEN      = 32,
   parameter int BHT_DEPTH = 16,
   parameter int PC_LSB    = 2,
   parameter int CNT_W     = 32
) (
   input logic                  clk_i,
   input logic                  rst_i,
   branch_predict_unit_if.slave bp
);
   localparam int         IDX_W   = $clog2(BHT_DEPTH);
   localparam logic [1:0] WEAK_NT = 2'b01;

   function automatic logic [1:0] ctr_sat_update(input logic [1:0] c, input logic up);
      if (up)
         return (c == 2'b11) ? c : c + 2'd1;
      return (c == 2'b00) ? c : c - 2'd1;
   endfunction

   function automatic logic [CNT_W-1:0] stat_sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   logic [1:0]             bht [BHT_DEPTH];
   logic [CNT_W-1:0]       br_cnt;
   logic [CNT_W-1:0]       mis_cnt;
   logic [IDX_W-1:0]       id_idx;
   logic [IDX_W-1:0]       ex_idx;
   logic signed [XLEN-1:0] rs1_s;
   logic signed [XLEN-1:0] rs2_s;
   logic                   legal_f3;
   logic                   cond;
   logic                   taken;
   logic                   valid_br;
   logic                   flush;

   assign id_idx = bp.id_pc_i[PC_LSB +: IDX_W];
   assign ex_idx = bp.ex_pc_i[PC_LSB +: IDX_W];
   assign rs1_s  = bp.ex_rs1_i;
   assign rs2_s  = bp.ex_rs2_i;

   // ID lookup reads the table as it stood before this edge's update.
   assign bp.pred_taken_o  = bp.id_branch_i & bht[id_idx][1];
   assign bp.pred_target_o = bp.id_pc_i + bp.id_imm_i;

   always_comb begin
      cond     = 1'b0;
      legal_f3 = 1'b1;
      case (bp.ex_func3_i)
         3'b000:  cond = (bp.ex_rs1_i == bp.ex_rs2_i);
         3'b001:  cond = (bp.ex_rs1_i != bp.ex_rs2_i);
         3'b100:  cond = (rs1_s <  rs2_s);
         3'b101:  cond = (rs1_s >= rs2_s);
         3'b110:  cond = (bp.ex_rs1_i <  bp.ex_rs2_i);
         3'b111:  cond = (bp.ex_rs1_i >= bp.ex_rs2_i);
         default: legal_f3 = 1'b0;
      endcase
   end

   // A stalled branch is held off and resolves once on the first unstalled cycle.
   assign taken    = bp.ex_branch_i & legal_f3 & cond;
   assign valid_br = bp.ex_branch_i & legal_f3 & ~bp.ex_stall_i;
   assign flush    = valid_br & (taken != bp.ex_pred_taken_i);

   assign bp.taken_o         = taken;
   assign bp.flush_o         = flush;
   assign bp.redirect_pc_o   = !flush ? '0 :
                               taken  ? bp.ex_pc_i + bp.ex_imm_i :
                                        bp.ex_pc_i + XLEN'(4);
   assign bp.br_count_o      = br_cnt;
   assign bp.mispred_count_o = mis_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < BHT_DEPTH; i++)
            bht[i] <= WEAK_NT;
      end else if (valid_br) begin
         bht[ex_idx] <= ctr_sat_update(bht[ex_idx], taken);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         br_cnt  <= '0;
         mis_cnt <= '0;
      end else begin
         if (valid_br)
            br_cnt <= stat_sat_inc(br_cnt);
         if (flush)
            mis_cnt <= stat_sat_inc(mis_cnt);
      end
   end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed scenarios plus randomized traffic
// checked against a table/counter model of the branch rules.
module tb_branch_predict_unit;
   localparam longint unsigned CMAX = 64'hFFFF_FFFF;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic rst2 = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   int               mb [16];
   longint unsigned  m_br;
   longint unsigned  m_mis;

   branch_predict_unit_if #(.XLEN(32), .CNT_W(32)) bus ();
   branch_predict_unit_if #(.XLEN(32), .CNT_W(4))  bus2 ();

   branch_predict_unit #(.XLEN(32), .BHT_DEPTH(16), .PC_LSB(2), .CNT_W(32)) dut (
      .clk_i(clk), .rst_i(rst), .bp(bus));
   branch_predict_unit #(.XLEN(32), .BHT_DEPTH(16), .PC_LSB(2), .CNT_W(4)) dut2 (
      .clk_i(clk), .rst_i(rst2), .bp(bus2));

   always #5 clk = ~clk;

   function automatic int m_idx(input logic [31:0] pc);
      return int'((pc >> 2) & 32'd15);
   endfunction

   function automatic bit m_legal(input logic [2:0] f);
      return !(f == 3'd2 || f == 3'd3);
   endfunction

   function automatic bit m_cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      case (f)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return int'(a) <  int'(b);
         3'd5:    return int'(a) >= int'(b);
         3'd6:    return a <  b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit e_taken();
      return bus.ex_branch_i && m_legal(bus.ex_func3_i) &&
             m_cond(bus.ex_func3_i, bus.ex_rs1_i, bus.ex_rs2_i);
   endfunction

   function automatic bit e_valid();
      return bus.ex_branch_i && m_legal(bus.ex_func3_i) && !bus.ex_stall_i;
   endfunction

   function automatic bit e_flush();
      return e_valid() && (e_taken() != bus.ex_pred_taken_i);
   endfunction

   function automatic logic [31:0] e_redir();
      if (!e_flush()) return 32'd0;
      return e_taken() ? bus.ex_pc_i + bus.ex_imm_i : bus.ex_pc_i + 32'd4;
   endfunction

   function automatic bit e_pred();
      return bus.id_branch_i && (mb[m_idx(bus.id_pc_i)] >= 2);
   endfunction

   task automatic model_edge();
      bit t;
      bit f;
      int k;
      if (rst) begin
         foreach (mb[i]) mb[i] = 1;
         m_br  = 0;
         m_mis = 0;
      end else if (e_valid()) begin
         t = e_taken();
         f = e_flush();
         k = m_idx(bus.ex_pc_i);
         mb[k] = t ? ((mb[k] == 3) ? 3 : mb[k] + 1) : ((mb[k] == 0) ? 0 : mb[k] - 1);
         if (m_br < CMAX) m_br++;
         if (f && m_mis < CMAX) m_mis++;
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.id_pc_i = '0;  bus.id_imm_i = '0;  bus.id_branch_i = 1'b0;
      bus.ex_branch_i = 1'b0; bus.ex_stall_i = 1'b0; bus.ex_pc_i = '0; bus.ex_imm_i = '0;
      bus.ex_rs1_i = '0; bus.ex_rs2_i = '0; bus.ex_func3_i = '0; bus.ex_pred_taken_i = 1'b0;
      bus2.id_pc_i = '0; bus2.id_imm_i = '0; bus2.id_branch_i = 1'b0;
      bus2.ex_branch_i = 1'b0; bus2.ex_stall_i = 1'b0; bus2.ex_pc_i = '0; bus2.ex_imm_i = '0;
      bus2.ex_rs1_i = '0; bus2.ex_rs2_i = '0; bus2.ex_func3_i = '0; bus2.ex_pred_taken_i = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      if (bus.br_count_o !== 32'd0) begin $display("FAIL reset_br_count got=%0d exp=0", bus.br_count_o); failures++; end
      checks++;
      if (bus.mispred_count_o !== 32'd0) begin $display("FAIL reset_mis_count got=%0d exp=0", bus.mispred_count_o); failures++; end
      checks++;
      if ({bus.taken_o, bus.flush_o, bus.pred_taken_o} !== 3'b000) begin
         $display("FAIL reset_idle_flags got=%b exp=000", {bus.taken_o, bus.flush_o, bus.pred_taken_o}); failures++;
      end
      checks++;
      if (bus.redirect_pc_o !== 32'd0) begin $display("FAIL reset_redirect got=%h exp=0", bus.redirect_pc_o); failures++; end
      checks++;
      bus.id_pc_i = 32'h40; bus.id_imm_i = 32'h10; bus.id_branch_i = 1'b1;
      #1;
      if (bus.pred_taken_o !== 1'b0) begin $display("FAIL reset_pred got=%b exp=0", bus.pred_taken_o); failures++; end
      checks++;
      if (bus.pred_target_o !== 32'h50) begin $display("FAIL reset_target got=%h exp=50", bus.pred_target_o); failures++; end
      checks++;
      bus.id_branch_i = 1'b0;
   endtask

   task automatic test_beq_train();
      bus.ex_branch_i = 1'b1; bus.ex_pc_i = 32'h40; bus.ex_imm_i = 32'h10;
      bus.ex_rs1_i = 32'd5; bus.ex_rs2_i = 32'd5; bus.ex_func3_i = 3'd0; bus.ex_pred_taken_i = 1'b0;
      #1;
      if ({bus.taken_o, bus.flush_o} !== 2'b11) begin $display("FAIL beq_taken_flush got=%b exp=11", {bus.taken_o, bus.flush_o}); failures++; end
      checks++;
      if (bus.redirect_pc_o !== 32'h50) begin $display("FAIL beq_redirect got=%h exp=50", bus.redirect_pc_o); failures++; end
      checks++;
      step();
      if (bus.mispred_count_o !== 32'd1) begin $display("FAIL beq_mis_count got=%0d exp=1", bus.mispred_count_o); failures++; end
      checks++;
      step();
      bus.ex_branch_i = 1'b0;
      bus.id_pc_i = 32'h40; bus.id_branch_i = 1'b1;
      #1;
      if (bus.pred_taken_o !== 1'b1) begin $display("FAIL beq_trained_pred got=%b exp=1", bus.pred_taken_o); failures++; end
      checks++;
      bus.id_branch_i = 1'b0;
   endtask

   task automatic test_signed_unsigned();
      bus.ex_branch_i = 1'b1; bus.ex_pc_i = 32'h100; bus.ex_imm_i = 32'h20;
      bus.ex_rs1_i = 32'hFFFF_FFFF; bus.ex_rs2_i = 32'd1; bus.ex_pred_taken_i = 1'b0;
      bus.ex_func3_i = 3'd4;
      #1;
      if (bus.taken_o !== 1'b1) begin $display("FAIL blt_taken got=%b exp=1", bus.taken_o); failures++; end
      checks++;
      bus.ex_func3_i = 3'd6;
      #1;
      if (bus.taken_o !== 1'b0) begin $display("FAIL bltu_taken got=%b exp=0", bus.taken_o); failures++; end
      checks++;
      bus.ex_func3_i = 3'd7; bus.ex_rs1_i = 32'd1; bus.ex_rs2_i = 32'hFFFF_FFFF; bus.ex_pred_taken_i = 1'b1;
      #1;
      if ({bus.taken_o, bus.flush_o} !== 2'b01) begin $display("FAIL bgeu_flush got=%b exp=01", {bus.taken_o, bus.flush_o}); failures++; end
      checks++;
      if (bus.redirect_pc_o !== 32'h104) begin $display("FAIL bgeu_redirect got=%h exp=104", bus.redirect_pc_o); failures++; end
      checks++;
      bus.ex_branch_i = 1'b0; bus.ex_pred_taken_i = 1'b0;
   endtask

   task automatic test_same_cycle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.id_pc_i = 32'h0C; bus.id_branch_i = 1'b1;
      bus.ex_branch_i = 1'b1; bus.ex_pc_i = 32'h0C; bus.ex_imm_i = 32'h8;
      bus.ex_rs1_i = 32'd7; bus.ex_rs2_i = 32'd7; bus.ex_func3_i = 3'd0; bus.ex_pred_taken_i = 1'b0;
      #1;
      if (bus.pred_taken_o !== 1'b0) begin $display("FAIL same_cycle_old got=%b exp=0", bus.pred_taken_o); failures++; end
      checks++;
      step();
      bus.ex_branch_i = 1'b0;
      #1;
      if (bus.pred_taken_o !== 1'b1) begin $display("FAIL same_cycle_next got=%b exp=1", bus.pred_taken_o); failures++; end
      checks++;
      bus.id_branch_i = 1'b0;
   endtask

   task automatic test_stall_illegal();
      longint unsigned b0;
      longint unsigned m0;
      b0 = m_br;
      m0 = m_mis;
      bus.ex_branch_i = 1'b1; bus.ex_pc_i = 32'h80; bus.ex_imm_i = 32'h40;
      bus.ex_rs1_i = 32'd1; bus.ex_rs2_i = 32'd2; bus.ex_func3_i = 3'd1; bus.ex_pred_taken_i = 1'b0;
      bus.ex_stall_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (bus.flush_o !== 1'b0) begin $display("FAIL stall_flush cyc=%0d got=%b exp=0", c, bus.flush_o); failures++; end
         checks++;
         step();
         if (64'(bus.br_count_o) !== b0) begin $display("FAIL stall_br_count cyc=%0d got=%0d exp=%0d", c, bus.br_count_o, b0); failures++; end
         checks++;
      end
      bus.ex_stall_i = 1'b0;
      #1;
      if (bus.flush_o !== 1'b1 || bus.redirect_pc_o !== 32'hC0) begin
         $display("FAIL unstall_flush got=%b/%h exp=1/c0", bus.flush_o, bus.redirect_pc_o); failures++;
      end
      checks++;
      step();
      bus.ex_branch_i = 1'b0;
      if (64'(bus.br_count_o) !== b0 + 1 || 64'(bus.mispred_count_o) !== m0 + 1) begin
         $display("FAIL unstall_counts got=%0d/%0d exp=%0d/%0d", bus.br_count_o, bus.mispred_count_o, b0 + 1, m0 + 1); failures++;
      end
      checks++;
      bus.ex_branch_i = 1'b1; bus.ex_func3_i = 3'd2; bus.ex_rs1_i = 32'd3; bus.ex_rs2_i = 32'd3; bus.ex_pred_taken_i = 1'b1;
      #1;
      if ({bus.taken_o, bus.flush_o} !== 2'b00) begin $display("FAIL illegal_f3_flags got=%b exp=00", {bus.taken_o, bus.flush_o}); failures++; end
      checks++;
      step();
      bus.ex_branch_i = 1'b0; bus.ex_pred_taken_i = 1'b0;
      if (64'(bus.br_count_o) !== b0 + 1) begin $display("FAIL illegal_f3_count got=%0d exp=%0d", bus.br_count_o, b0 + 1); failures++; end
      checks++;
   endtask

   function automatic logic [31:0] pick_op();
      case ($urandom_range(0, 5))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'h8000_0000;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 59) == 0);
         bus.id_pc_i = ($urandom & 32'hFC) | (32'($urandom_range(0, 3)) << 12);
         bus.id_imm_i = $urandom; bus.id_branch_i = $urandom_range(0, 1);
         bus.ex_pc_i = ($urandom & 32'hFC) | (32'($urandom_range(0, 3)) << 12);
         bus.ex_imm_i = $urandom; bus.ex_branch_i = ($urandom_range(0, 3) != 0);
         bus.ex_stall_i = ($urandom_range(0, 4) == 0); bus.ex_pred_taken_i = $urandom_range(0, 1);
         bus.ex_func3_i = 3'($urandom_range(0, 7));
         bus.ex_rs1_i = pick_op();
         bus.ex_rs2_i = ($urandom_range(0, 3) == 0) ? bus.ex_rs1_i : pick_op();
         #1;
         if (bus.pred_taken_o !== e_pred() || bus.pred_target_o !== bus.id_pc_i + bus.id_imm_i) begin
            $display("FAIL rand_pred n=%0d got=%b/%h exp=%b/%h", n, bus.pred_taken_o, bus.pred_target_o,
                     e_pred(), bus.id_pc_i + bus.id_imm_i); failures++;
         end
         checks++;
         if (bus.taken_o !== e_taken() || bus.flush_o !== e_flush() || bus.redirect_pc_o !== e_redir()) begin
            $display("FAIL rand_resolve n=%0d got=%b/%b/%h exp=%b/%b/%h", n, bus.taken_o, bus.flush_o,
                     bus.redirect_pc_o, e_taken(), e_flush(), e_redir()); failures++;
         end
         checks++;
         step();
         if (64'(bus.br_count_o) !== m_br || 64'(bus.mispred_count_o) !== m_mis) begin
            $display("FAIL rand_counts n=%0d got=%0d/%0d exp=%0d/%0d", n, bus.br_count_o, bus.mispred_count_o,
                     m_br, m_mis); failures++;
         end
         checks++;
      end
      rst = 1'b0;
      idle();
   endtask

   task automatic test_counter_sat();
      rst2 = 1'b1;
      step();
      rst2 = 1'b0;
      bus2.ex_branch_i = 1'b1; bus2.ex_pc_i = 32'h40; bus2.ex_imm_i = 32'h10;
      bus2.ex_rs1_i = 32'd9; bus2.ex_rs2_i = 32'd9; bus2.ex_func3_i = 3'd0; bus2.ex_pred_taken_i = 1'b0;
      repeat (16) step();
      if (bus2.mispred_count_o !== 4'd15 || bus2.br_count_o !== 4'd15) begin
         $display("FAIL sat_16 got=%0d/%0d exp=15/15", bus2.mispred_count_o, bus2.br_count_o); failures++;
      end
      checks++;
      step();
      if (bus2.mispred_count_o !== 4'd15) begin $display("FAIL sat_hold got=%0d exp=15", bus2.mispred_count_o); failures++; end
      checks++;
      rst2 = 1'b1;
      step();
      rst2 = 1'b0;
      bus2.ex_branch_i = 1'b0;
      bus2.id_pc_i = 32'h40; bus2.id_branch_i = 1'b1;
      #1;
      if (bus2.br_count_o !== 4'd0 || bus2.mispred_count_o !== 4'd0 || bus2.pred_taken_o !== 1'b0) begin
         $display("FAIL rst_with_branch got=%0d/%0d/%b exp=0/0/0", bus2.br_count_o, bus2.mispred_count_o,
                  bus2.pred_taken_o); failures++;
      end
      checks++;
      bus2.ex_branch_i = 1'b1;
      step();
      bus2.ex_branch_i = 1'b0;
      #1;
      if (bus2.pred_taken_o !== 1'b1 || bus2.mispred_count_o !== 4'd1) begin
         $display("FAIL rst_entry_weak got=%b/%0d exp=1/1", bus2.pred_taken_o, bus2.mispred_count_o); failures++;
      end
      checks++;
      bus2.id_branch_i = 1'b0;
   endtask

   initial begin
      idle();
      test_reset();
      test_beq_train();
      test_signed_unsigned();
      test_same_cycle();
      test_stall_illegal();
      test_random();
      test_counter_sat();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
